fb_scan_arbiter: RTL and testbench
==================================

Name: fb_scan_arbiter

Overview:
- Owns the single-port, 1-cycle-latency framebuffer RAM. Stores 160x120 cells, 12-bit colour.
- Shares the RAM between three users: display scan-out (driven by the timing generator's hdata/vdata/valid), a game-logic writer, and a built-in clear engine.
- Produces the 640x480 pixel colour by replicating each framebuffer cell 4x4.

Parameters:
- HSIZE, 640, visible pixels per line
- HMAX, 800, total clocks per line
- VSIZE, 480, visible lines
- VMAX, 525, total lines
- FB_W, 160, framebuffer width (HSIZE/4)
- FB_H, 120, framebuffer height (VSIZE/4)
- AW, 15, RAM address width
- CW, 12, colour width

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hdata  in  12  horizontal counter from timing generator
- vdata  in  12  vertical counter from timing generator
- valid  in  1  visible-region flag from timing generator (informational; blanking derived internally)
- wr_req  in  1  writer request, held until wr_ack
- wr_addr  in  AW  writer cell address (y*FB_W + x)
- wr_data  in  CW  writer colour
- wr_ack  out  1  combinational; high in the cycle the write is issued
- clr_req  in  1  start full-framebuffer clear
- clr_color  in  CW  clear colour, latched at start
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last clear write
- ram_addr  out  AW  combinational RAM address
- ram_we  out  1  combinational RAM write enable
- ram_wdata  out  CW  combinational RAM write data
- ram_rdata  in  CW  RAM read data, valid the cycle after address
- rgb  out  CW  registered pixel colour, 0 during blanking

Behaviour:
- Reset (async, rst_n=0):
  - rgb=0, clr_busy=0, clr_done=0.
  - Clear pointer=0, FSM=IDLE, internal flags=0.
  - Combinational outputs follow from that state.
- Display slot: any cycle with hdata[1:0]==2'b10 where the target block is visible.
  - For hdata<HMAX-2: target = block (hdata>>2)+1 on line vdata. Visible iff (hdata>>2)+1 < FB_W and vdata < VSIZE.
  - For hdata==HMAX-2: target = block 0 of line nv, where nv = (vdata==VMAX-1) ? 0 : vdata+1. Visible iff nv < VSIZE.
- In a display slot: ram_we=0, ram_addr=(line>>2)*FB_W + block. A vis flag is registered.
- In every cycle with hdata[1:0]==2'b11: rgb <= vis ? ram_rdata : 0.
  - rgb therefore shows block b across hdata 4b..4b+3; block 0 is loaded at hdata=HMAX-1.
  - Result: a 2-cycle fixed pipeline, aligned so rgb is correct in the cycle the timing generator reports that pixel.
- All other cycles are write slots. Priority: display > clear > writer.
- Writer, in a write slot with FSM=IDLE and wr_req=1:
  - wr_ack=1.
  - If wr_addr < FB_W*FB_H: ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
  - Out-of-range address: acked, ram_we=0 (dropped).
  - The writer must hold request/address/data until it samples wr_ack=1 at a clock edge.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1 at an edge. Latches clr_color, ptr<=0, clr_busy=1.
  - In CLEAR, each write slot: ram_we=1, ram_addr=ptr, ram_wdata=latched colour, ptr<=ptr+1. wr_ack is held 0.
  - When ptr==FB_W*FB_H-1 is written: next state IDLE, ptr<=0, clr_busy<=0, clr_done pulses 1 for one cycle.
  - clr_req while in CLEAR is ignored. clr_req in the same cycle as clr_done is honoured on the following edge (FSM already IDLE).
  - Simultaneous wr_req and clr_req in IDLE: the writer gets the current slot if it is a write slot; CLEAR starts at that edge.
- Reset mid-clear: clear is aborted, no clr_done, framebuffer contents undefined.
- Any timing-counter wrap or line change is handled purely from hdata/vdata; no internal line counter.

Test Plan:
- Post-reset with no requests, preloaded RAM (cell n = n[11:0]), full frame scanned:
  - rgb at (h=8..11, v=4..7) equals cell 162.
  - rgb=0 for h>=640 or v>=480.
  - rgb at (0,0) equals cell 0 in the same cycle hdata=0.
- Writer writes addr 161 = 0xABC with wr_req held:
  - wr_ack only in cycles with hdata[1:0]!=2 or in blanking.
  - The next frame shows 0xABC at pixels (4..7, 4..7).
- clr_req with clr_color=0x0F0:
  - clr_busy for the duration; exactly 19200 writes covering addresses 0..19199 once each.
  - clr_done is a single pulse; no wr_ack during busy.
  - The following frame shows all visible pixels = 0x0F0.
- wr_addr=19200 -> acked, ram_we stays 0.
- Concurrent wr_req and clr_req: wr_ack withheld while busy, granted after clr_done.
- rst_n asserted mid-clear at ptr=5000:
  - clr_busy=0 and rgb=0 immediately, no clr_done.
  - A new clr_req restarts from ptr 0.

Source files
------------

// File: rtl/fb_scan_arbiter.sv
// Framebuffer RAM arbiter: 4x4-replicated 160x120 scan-out, game-logic writer and clear engine
// sharing one single-port RAM. Display slots win, then the clear engine, then the writer.
module fb_scan_arbiter #(
    parameter int HSIZE = 640,
    parameter int HMAX  = 800,
    parameter int VSIZE = 480,
    parameter int VMAX  = 525,
    parameter int FB_W  = 160,
    parameter int FB_H  = 120,
    parameter int AW    = 15,
    parameter int CW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [11:0]   hdata,
    input  logic [11:0]   vdata,
    input  logic          valid,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [CW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          clr_req,
    input  logic [CW-1:0] clr_color,
    output logic          clr_busy,
    output logic          clr_done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [CW-1:0] ram_wdata,
    input  logic [CW-1:0] ram_rdata,
    output logic [CW-1:0] rgb
);

    localparam logic [11:0]   H_WRAP    = 12'(HMAX - 2);
    localparam logic [11:0]   V_LAST    = 12'(VMAX - 1);
    localparam logic [11:0]   V_VIS     = 12'(VSIZE);
    localparam logic [11:0]   B_VIS     = 12'(HSIZE / 4);
    localparam logic [AW-1:0] CELLS     = AW'(FB_W * FB_H);
    localparam logic [AW-1:0] LAST_CELL = AW'(FB_W * FB_H - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] color_q, color_d;
    logic [CW-1:0] rgb_q, rgb_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          vis_q, vis_d;

    logic [11:0]   nv, line, blk;
    logic          disp;
    logic [AW-1:0] disp_addr;

    // The timing generator's visible flag is redundant with hdata/vdata.
    logic unused_valid;
    assign unused_valid = valid;

    // Fetch one block ahead: the slot at hdata=4b+2 loads block b+1; the wrap slot
    // at the end of a line loads block 0 of the next line.
    always_comb begin
        nv = (vdata == V_LAST) ? '0 : vdata + 12'd1;
        if (hdata == H_WRAP) begin
            line = nv;
            blk  = '0;
        end else begin
            line = vdata;
            blk  = {2'b00, hdata[11:2]} + 12'd1;
        end
        disp      = (hdata[1:0] == 2'b10) && (line < V_VIS) && (blk < B_VIS);
        disp_addr = AW'(line[11:2]) * AW'(FB_W) + AW'(blk);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        color_d   = color_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ram_addr  = disp_addr;
        ram_we    = 1'b0;
        ram_wdata = '0;
        wr_ack    = 1'b0;

        if (disp) begin
            ram_addr = disp_addr;
        end else if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = ptr_q;
            ram_wdata = color_q;
            if (ptr_q == LAST_CELL) begin
                state_d = IDLE;
                ptr_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end else if (wr_req) begin
            wr_ack   = 1'b1;
            ram_addr = wr_addr;
            if (wr_addr < CELLS) begin
                ram_we    = 1'b1;
                ram_wdata = wr_data;
            end
        end

        if (state_q == IDLE && clr_req) begin
            state_d = CLEAR;
            ptr_d   = '0;
            color_d = clr_color;
            busy_d  = 1'b1;
        end

        vis_d = vis_q;
        if (hdata[1:0] == 2'b10) vis_d = disp;

        rgb_d = rgb_q;
        if (hdata[1:0] == 2'b11) rgb_d = vis_q ? ram_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            color_q <= '0;
            rgb_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            color_q <= color_d;
            rgb_q   <= rgb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vis_q   <= vis_d;
        end
    end

    assign rgb      = rgb_q;
    assign clr_busy = busy_q;
    assign clr_done = done_q;

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench for fb_scan_arbiter: drives hdata/vdata directly, models the 1-cycle RAM,
// and compares scan-out, writer and clear behaviour against hand-derived expectations.
module tb_fb_scan_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] hdata, vdata;
    logic        valid;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack;
    logic        clr_req;
    logic [11:0] clr_color;
    logic        clr_busy, clr_done;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [11:0] ram_wdata, ram_rdata, rgb;

    int total = 0;
    int bad   = 0;
    int th, tv;
    logic [11:0] cap  [0:799];
    logic [11:0] gold [0:19199];
    logic [11:0] mem  [0:32767];
    logic        loaded = 1'b0;

    always #5 clk = ~clk;

    assign valid = (hdata < 12'd640) && (vdata < 12'd480);

    fb_scan_arbiter dut (
        .clk(clk), .rst_n(rst_n), .hdata(hdata), .vdata(vdata), .valid(valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rgb(rgb)
    );

    // Single-port RAM, 1-cycle read latency; preloaded with cell n = n[11:0] during reset.
    always @(posedge clk) begin
        if (!rst_n && !loaded) begin
            for (int n = 0; n < 19200; n++) mem[n] <= 12'(n);
            loaded <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    function automatic logic [11:0] exp_px(input int h, input int v);
        if (h < 640 && v < 480) return gold[(v / 4) * 160 + h / 4];
        return 12'h000;
    endfunction

    task automatic apply(input int h, input int v);
        th = h; tv = v;
        hdata = 12'(h); vdata = 12'(v);
    endtask

    task automatic step();
        @(posedge clk); #1;
        if (th == 799) begin
            th = 0;
            tv = (tv == 524) ? 0 : tv + 1;
        end else begin
            th = th + 1;
        end
        hdata = 12'(th); vdata = 12'(tv);
    endtask

    // Feeds a contiguous run of pixels ending at (he, v) and records rgb for hs..he.
    task automatic capture(input int v, input int hs, input int he);
        if (hs >= 4) apply(hs - 4, v);
        else apply(796, (v == 0) ? 524 : v - 1);
        for (int k = 0; k < 1700; k++) begin
            @(negedge clk);
            if (tv == v && th >= hs && th <= he) cap[th] = rgb;
            if (tv == v && th == he) break;
            step();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        clr_req = 1'b0; clr_color = '0;
        apply(0, 0);
        repeat (2) @(negedge clk);
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb: got %h want 000", rgb); end
        total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", clr_busy); end
        total++; if (clr_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", clr_done); end
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", wr_ack); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", ram_we); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        for (int n = 0; n < 19200; n++) gold[n] = 12'(n);
        capture(4, 0, 15);
        total++; if (cap[8] !== 12'd162) begin bad++; $display("FAIL scan_cell162: got %h want %h", cap[8], 12'd162); end
        for (int h = 0; h <= 15; h++) begin
            total++;
            if (cap[h] !== exp_px(h, 4)) begin bad++; $display("FAIL scan v=4 h=%0d: got %h want %h", h, cap[h], exp_px(h, 4)); end
        end
        for (int v = 5; v <= 7; v++) begin
            capture(v, 8, 11);
            for (int h = 8; h <= 11; h++) begin
                total++;
                if (cap[h] !== 12'd162) begin bad++; $display("FAIL scan v=%0d h=%0d: got %h want %h", v, h, cap[h], 12'd162); end
            end
        end
        capture(4, 628, 799);
        for (int h = 628; h <= 799; h++) begin
            total++;
            if (cap[h] !== exp_px(h, 4)) begin bad++; $display("FAIL hblank v=4 h=%0d: got %h want %h", h, cap[h], exp_px(h, 4)); end
        end
        capture(480, 0, 15);
        for (int h = 0; h <= 15; h++) begin
            total++;
            if (cap[h] !== 12'h000) begin bad++; $display("FAIL vblank v=480 h=%0d: got %h want 000", h, cap[h]); end
        end
        capture(0, 0, 7);
        for (int h = 0; h <= 7; h++) begin
            total++;
            if (cap[h] !== exp_px(h, 0)) begin bad++; $display("FAIL scan v=0 h=%0d: got %h want %h", h, cap[h], exp_px(h, 0)); end
        end
    endtask

    task automatic test_writer();
        apply(2, 4);
        wr_req = 1'b1; wr_addr = 15'd161; wr_data = 12'hABC;
        @(negedge clk);
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL wr_disp_slot_ack: got %b want 0", wr_ack); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL wr_disp_slot_we: got %b want 0", ram_we); end
        step();
        @(negedge clk);
        total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL wr_ack: got %b want 1", wr_ack); end
        total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL wr_we: got %b want 1", ram_we); end
        total++; if (ram_addr !== 15'd161) begin bad++; $display("FAIL wr_addr: got %0d want 161", ram_addr); end
        total++; if (ram_wdata !== 12'hABC) begin bad++; $display("FAIL wr_wdata: got %h want abc", ram_wdata); end
        @(posedge clk); #1;
        wr_req = 1'b0;
        gold[161] = 12'hABC;

        apply(638, 4);
        wr_req = 1'b1; wr_addr = 15'd0; wr_data = 12'h555;
        @(negedge clk);
        total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL wr_edge_ack: got %b want 1", wr_ack); end
        total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL wr_edge_we: got %b want 1", ram_we); end
        @(posedge clk); #1;
        wr_req = 1'b0;
        gold[0] = 12'h555;

        apply(702, 4);
        wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 12'hFFF;
        @(negedge clk);
        total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL wr_oor_ack: got %b want 1", wr_ack); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL wr_oor_we: got %b want 0", ram_we); end
        @(posedge clk); #1;
        wr_req = 1'b0;

        for (int v = 4; v <= 7; v++) begin
            capture(v, 0, 11);
            for (int h = 0; h <= 11; h++) begin
                total++;
                if (cap[h] !== exp_px(h, v)) begin bad++; $display("FAIL wr_frame v=%0d h=%0d: got %h want %h", v, h, cap[h], exp_px(h, v)); end
            end
        end
        capture(0, 0, 3);
        total++; if (cap[0] !== 12'h555) begin bad++; $display("FAIL wr_frame_cell0: got %h want 555", cap[0]); end
    endtask

    task automatic test_clear_concurrent();
        int  nwr = 0, order_err = 0, ack_busy = 0, pulse = 0;
        logic done_seen = 1'b0, done_busy = 1'b1, granted = 1'b0;
        apply(3, 20);
        clr_req = 1'b1; clr_color = 12'h0F0;
        wr_req = 1'b1; wr_addr = 15'd100; wr_data = 12'h321;
        @(negedge clk);
        total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL cc_first_ack: got %b want 1", wr_ack); end
        total++; if (ram_addr !== 15'd100) begin bad++; $display("FAIL cc_first_addr: got %0d want 100", ram_addr); end
        total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL cc_busy_before: got %b want 0", clr_busy); end
        step();
        clr_req = 1'b0; clr_color = 12'h000; wr_addr = 15'd5; wr_data = 12'h777;
        for (int k = 0; k < 30000; k++) begin
            @(negedge clk);
            if (clr_busy) begin
                if (wr_ack) ack_busy++;
                if (ram_we) begin
                    if (ram_addr !== 15'(nwr) || ram_wdata !== 12'h0F0) order_err++;
                    nwr++;
                end
            end
            if (clr_done) begin done_seen = 1'b1; done_busy = clr_busy; break; end
            if (nwr == 8000 && pulse == 0) begin clr_req = 1'b1; clr_color = 12'hF00; pulse = 1; end
            step();
            if (pulse == 1) begin clr_req = 1'b0; pulse = 2; end
        end
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL clr_done_timeout: got %b want 1", done_seen); end
        total++; if (nwr != 19200) begin bad++; $display("FAIL clr_write_count: got %0d want 19200", nwr); end
        total++; if (order_err != 0) begin bad++; $display("FAIL clr_addr_data_order: got %0d errors want 0", order_err); end
        total++; if (ack_busy != 0) begin bad++; $display("FAIL clr_ack_while_busy: got %0d want 0", ack_busy); end
        total++; if (done_busy !== 1'b0) begin bad++; $display("FAIL clr_busy_at_done: got %b want 0", done_busy); end
        granted = wr_ack;
        step();
        if (granted) wr_req = 1'b0;
        @(negedge clk);
        total++; if (clr_done !== 1'b0) begin bad++; $display("FAIL clr_done_width: got %b want 0", clr_done); end
        for (int k = 0; k < 8 && !granted; k++) begin
            granted = wr_ack;
            if (granted) begin
                step();
                wr_req = 1'b0;
            end else begin
                step();
                @(negedge clk);
            end
        end
        total++; if (granted !== 1'b1) begin bad++; $display("FAIL cc_grant_after_done: got %b want 1", granted); end
        wr_req = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 19200; n++) gold[n] = 12'h0F0;
        gold[5] = 12'h777;
        capture(0, 0, 31);
        for (int h = 0; h <= 31; h++) begin
            total++;
            if (cap[h] !== exp_px(h, 0)) begin bad++; $display("FAIL clr_frame v=0 h=%0d: got %h want %h", h, cap[h], exp_px(h, 0)); end
        end
        capture(479, 620, 660);
        for (int h = 620; h <= 660; h++) begin
            total++;
            if (cap[h] !== exp_px(h, 479)) begin bad++; $display("FAIL clr_frame v=479 h=%0d: got %h want %h", h, cap[h], exp_px(h, 479)); end
        end
        capture(240, 0, 15);
        for (int h = 0; h <= 15; h++) begin
            total++;
            if (cap[h] !== 12'h0F0) begin bad++; $display("FAIL clr_frame v=240 h=%0d: got %h want 0f0", h, cap[h]); end
        end
    endtask

    task automatic test_reset_mid_clear();
        int nwr = 0, dones = 0, busys = 0;
        logic found = 1'b0;
        apply(100, 30);
        clr_req = 1'b1; clr_color = 12'hA5A;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            if (clr_busy && ram_we) nwr++;
            if (nwr == 5000) break;
            step();
        end
        total++; if (nwr != 5000) begin bad++; $display("FAIL mid_reach_5000: got %0d want 5000", nwr); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", clr_busy); end
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL mid_rst_rgb: got %h want 000", rgb); end
        total++; if (clr_done !== 1'b0) begin bad++; $display("FAIL mid_rst_done: got %b want 0", clr_done); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(0, 40);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (clr_done) dones++;
            if (clr_busy) busys++;
            step();
        end
        total++; if (dones != 0) begin bad++; $display("FAIL mid_no_done: got %0d pulses want 0", dones); end
        total++; if (busys != 0) begin bad++; $display("FAIL mid_no_busy: got %0d cycles want 0", busys); end
        clr_req = 1'b1; clr_color = 12'h3C3;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (clr_busy && ram_we) begin
                found = 1'b1;
                total++; if (ram_addr !== 15'd0) begin bad++; $display("FAIL restart_addr: got %0d want 0", ram_addr); end
                total++; if (ram_wdata !== 12'h3C3) begin bad++; $display("FAIL restart_data: got %h want 3c3", ram_wdata); end
                break;
            end
            step();
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL restart_timeout: got %b want 1", found); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_writer();
        test_clear_concurrent();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
